// File: rtl/div5_arb_pkg.sv
// Shared definitions for the div5_arbiter slice.
//   - X/Q/R operand widths (16/14/3) and the constant divisor (5)
//   - Pipeline entry structs for stage S1 (operand) and stage S2 (result)
// Optional feature macro: DIV5_ARB_SELFCHECK_EN adds a dividend copy to the
// S2 entry so the result can be re-multiplied and checked.
package div5_arb_pkg;

  localparam int X_W     = 16;
  localparam int Q_W     = 14;
  localparam int R_W     = 3;
  localparam int DIVISOR = 5;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Q_W-1:0] q_t;
  typedef logic [R_W-1:0] r_t;

  // S1 holds the accepted dividend; the requester id travels beside it in
  // a separately sized register because its width is a module parameter.
  typedef struct packed {
    logic valid;
    x_t   x;
  } s1_entry_t;

  // S2 holds the registered quotient/remainder.
  typedef struct packed {
    logic valid;
    q_t   q;
    r_t   r;
`ifdef DIV5_ARB_SELFCHECK_EN
    x_t   x;
`endif
  } s2_entry_t;

endpackage

// File: rtl/div5_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant selection with a rotating search pointer.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset (pointer -> 0)
//   req          in   NUM_REQ request vector
//   advance      in   a grant was actually taken this cycle
//   grant_valid  out  some requester is selected
//   grant_id     out  index of the selected requester
//   grant_oh     out  one-hot form of grant_id (zero when none)
// ptr is the index where the next search begins, i.e. one past the last
// requester that actually transferred. It starts at 0 so the first grant
// after reset goes to the lowest valid index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] grant_oh
);

  logic [ID_W-1:0] ptr;

  // Scan from the farthest candidate back to ptr so the candidate nearest
  // to ptr (in wrap order) is the last one written and therefore wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    idx         = 0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
    if (grant_valid) grant_oh[grant_id] = 1'b1;
  end

  // Pointer moves only on a real transfer; stalls leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/div_16_5.sv
// div_16_5: combinational unsigned divide of a 16-bit value by 5.
// Ports:
//   x  in  16  dividend
//   q  out 14  floor(x / 5)
//   r  out  3  x mod 5
// Restoring long division, one quotient bit per dividend bit. The two top
// quotient bits are always zero (65535/5 = 13107 < 2^14), so the partial
// remainder is seeded with x[15:14] and the loop produces q[13:0].
module div_16_5 (
  input  logic [15:0] x,
  output logic [13:0] q,
  output logic [2:0]  r
);

  always_comb begin
    logic [3:0] t;
    logic [2:0] rem;
    q   = '0;
    t   = '0;
    rem = {1'b0, x[15:14]};
    for (int i = 13; i >= 0; i--) begin
      t = {rem, x[i]};
      if (t >= 4'd5) begin
        q[i] = 1'b1;
        t    = t - 4'd5;
      end
      rem = t[2:0];
    end
    r = rem;
  end

endmodule

// File: rtl/div5_arbiter.sv
// div5_arbiter: NUM_REQ requesters share one divide-by-5 core through a
// round-robin arbiter and a two-stage pipeline (S1 operand, S2 result).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   NUM_REQ    per-requester operand valid
//   req_x      in   NUM_REQ*16 packed dividends, requester i at [16*i +: 16]
//   req_ready  out  NUM_REQ    one-hot (or zero) accept
//   rsp_valid  out  1          result valid
//   rsp_ready  in   1          downstream accept
//   rsp_id     out  ID_W       owning requester index
//   rsp_q      out  14         floor(X/5)
//   rsp_r      out  3          X mod 5
//   busy       out  1          a pipeline stage holds an entry
//   chk_err    out  1          sticky self-check error
// Optional feature macro: DIV5_ARB_SELFCHECK_EN enables the 5*Q+R==X check
// on the S2 entry; without it chk_err is constant 0.
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// high at the rising edge. A producer keeps valid and data stable until it
// sees ready; ready never depends on the consumer's own valid in a way that
// forms a loop. Requesters may withdraw valid before being granted, in which
// case nothing is recorded. While rsp_valid is high and rsp_ready is low the
// response fields hold their value.
module div5_arbiter
  import div5_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*16-1:0]  req_x,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [13:0]            rsp_q,
  output logic [2:0]             rsp_r,
  output logic                   busy,
  output logic                   chk_err
);

  s1_entry_t          s1;
  logic [ID_W-1:0]    s1_id;
  s2_entry_t          s2;
  logic [ID_W-1:0]    s2_id;

  // Low for exactly one cycle after reset so no grant is issued then.
  logic               ready_en;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_oh;
  logic               s2_load;
  logic               s1_load;
  logic               xfer;
  x_t                 sel_x;
  q_t                 core_q;
  r_t                 core_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .advance     (xfer),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_oh    (grant_oh)
  );

  div_16_5 u_core (
    .x (s1.x),
    .q (core_q),
    .r (core_r)
  );

  // S2 frees up when empty or when its result is being taken; S1 can then
  // move forward, which is what lets a grant and a response share a cycle.
  assign s2_load   = !s2.valid || rsp_ready;
  assign s1_load   = !s1.valid || s2_load;
  assign xfer      = grant_valid && s1_load && ready_en && !rst;
  assign req_ready = xfer ? grant_oh : '0;
  assign sel_x     = req_x[{grant_id, 4'b0000} +: X_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s1_id    <= '0;
      s2       <= '0;
      s2_id    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (s2_load) begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.q  <= core_q;
          s2.r  <= core_r;
          s2_id <= s1_id;
`ifdef DIV5_ARB_SELFCHECK_EN
          s2.x  <= s1.x;
`endif
        end
      end
      if (s1_load) begin
        s1.valid <= xfer;
        if (xfer) begin
          s1.x  <= sel_x;
          s1_id <= grant_id;
        end
      end
    end
  end

  // Outputs read zero while reset is held, not just after it.
  assign rsp_valid = s2.valid && !rst;
  assign rsp_id    = rst ? '0 : s2_id;
  assign rsp_q     = rst ? '0 : s2.q;
  assign rsp_r     = rst ? '0 : s2.r;
  assign busy      = (s1.valid || s2.valid) && !rst;

`ifdef DIV5_ARB_SELFCHECK_EN
  // Re-multiply the entry held in S2 and compare against its dividend copy.
  logic [16:0] recon;
  logic        chk_bad;
  logic        chk_err_q;

  assign recon   = 17'(s2.q) * 17'(DIVISOR) + 17'(s2.r);
  assign chk_bad = s2.valid && ((recon != {1'b0, s2.x}) || (s2.r >= R_W'(DIVISOR)));

  always_ff @(posedge clk) begin
    if (rst) chk_err_q <= 1'b0;
    else if (chk_bad) chk_err_q <= 1'b1;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
